bike_bram_poly_reader: RTL

- Read-side controller for the shared dual-polynomial BRAM. On `start`, it streams one stored polynomial (poly 0 via port A, or poly 1 via port B) out of the BRAM as 32-bit words on a valid/ready interface.
- Hides the 1-cycle BRAM read latency with a 2-entry output buffer.
- Masks the unused high bits of the final word.
- Sits between the shared BRAM's sampling-side 32-bit ports and result-output or hashing logic.

---
 rtl/bike_bram_poly_reader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/bike_bram_poly_reader.sv
// Streams one polynomial out of the shared dual-polynomial BRAM as 32-bit valid/ready words.
// A 2-entry output buffer hides the 1-cycle BRAM read latency; the final word is masked.
`timescale 1ns/1ps

module bike_bram_poly_reader #(
    parameter int          NUM_WORDS = 386,
    parameter int          ADDR_W    = 9,
    parameter logic [31:0] LAST_MASK = 32'h0000_0007
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              sel,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              ren0,
    output logic              ren1,
    output logic [ADDR_W-1:0] addr,
    input  logic [31:0]       dout0,
    input  logic [31:0]       dout1,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [31:0]       m_data,
    output logic              m_last
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    state_t            state_q, state_d;
    logic              sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;
    logic [1:0]        count_q, count_d;
    logic [31:0]       data0_q, data0_d;
    logic [31:0]       data1_q, data1_d;
    logic              last0_q, last0_d;
    logic              last1_q, last1_d;

    logic              pop;
    logic              issue;
    logic              is_last_addr;
    logic [1:0]        room_used;
    logic [31:0]       cap_data;

    assign is_last_addr = (addr_q == LAST_ADDR);
    assign room_used    = count_q + {1'b0, inflight_q};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the buffer is only two words, so it is reset like any other flop to give m_data a defined 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q           <= 1'b0;
            addr_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            count_q         <= 2'd0;
            data0_q         <= 32'd0;
            data1_q         <= 32'd0;
            last0_q         <= 1'b0;
            last1_q         <= 1'b0;
        end else begin
            sel_q           <= sel_d;
            addr_q          <= addr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            count_q         <= count_d;
            data0_q         <= data0_d;
            data1_q         <= data1_d;
            last0_q         <= last0_d;
            last1_q         <= last1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = READ;
            READ:  if (issue && is_last_addr) state_d = DRAIN;
            DRAIN: if (pop && last0_q) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // A read may issue only if the word it returns is guaranteed a buffer slot.
    always_comb begin
        pop     = (count_q != 2'd0) && m_ready;
        issue   = (state_q == READ) &&
                  ((room_used < 2'd2) || ((room_used == 2'd2) && pop));
        ren0    = issue && !sel_q;
        ren1    = issue && sel_q;
        addr    = addr_q;
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        m_valid = (count_q != 2'd0);
        m_data  = data0_q;
        m_last  = last0_q && m_valid;
    end

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        sel_d           = sel_q;
        addr_d          = addr_q;
        inflight_d      = issue;
        inflight_last_d = issue && is_last_addr;
        count_d         = count_q;
        data0_d         = data0_q;
        data1_d         = data1_q;
        last0_d         = last0_q;
        last1_d         = last1_q;

        cap_data = sel_q ? dout1 : dout0;
        if (inflight_last_q) cap_data = cap_data & LAST_MASK;

        if (state_q == IDLE && start) begin
            sel_d  = sel;
            addr_d = '0;
        end else if (issue && !is_last_addr) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        // A push only happens with at most one word buffered, so slot 1 never overflows.
        unique case ({inflight_q, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    data0_d = cap_data;
                    last0_d = inflight_last_q;
                end else begin
                    data1_d = cap_data;
                    last1_d = inflight_last_q;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                data0_d = data1_q;
                last0_d = last1_q;
                last1_d = 1'b0;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                data0_d = cap_data;
                last0_d = inflight_last_q;
            end
            default: ;
        endcase

        if (abort) begin
            count_d         = 2'd0;
            inflight_d      = 1'b0;
            inflight_last_d = 1'b0;
            last0_d         = 1'b0;
            last1_d         = 1'b0;
        end
    end

endmodule
